// File: rtl/boot_rom_arbiter.sv
// Boot ROM slave-port arbiter: round-robin selection among NB_MASTERS
// TCDM-style requesters, one ROM access per cycle, one-cycle response
// routed back to the issuing master. Writes and out-of-window reads are
// answered locally with an error response on the same one-cycle timing.
module boot_rom_arbiter #(
    parameter int          NB_MASTERS     = 2,
    parameter int          ROM_ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
    parameter logic [31:0] ERR_RDATA      = 32'hBADA_CCE5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NB_MASTERS-1:0]       m_req_i,
    input  logic [NB_MASTERS-1:0][31:0] m_add_i,
    input  logic [NB_MASTERS-1:0]       m_wen_i,
    output logic [NB_MASTERS-1:0]       m_gnt_o,
    output logic [NB_MASTERS-1:0]       m_r_valid_o,
    output logic [NB_MASTERS-1:0][31:0] m_r_rdata_o,
    output logic [NB_MASTERS-1:0]       m_r_opc_o,
    output logic                        s_req_o,
    output logic [31:0]                 s_add_o,
    input  logic                        s_gnt_i,
    input  logic                        s_r_valid_i,
    input  logic [31:0]                 s_r_rdata_i
);

    // Pointer width; a single master still gets a 1-bit pointer that stays 0.
    localparam int RR_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam logic [RR_W:0]   NB_L = (RR_W+1)'(NB_MASTERS);
    localparam logic [RR_W-1:0] LAST = RR_W'(NB_MASTERS - 1);

    // Window bounds in 33 bits so a window ending at 2^32 does not wrap to 0.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << ROM_ADDR_WIDTH);

    logic [RR_W-1:0]       rr_q, rr_d;
    logic                  resp_vld_q, resp_vld_d;
    logic [RR_W-1:0]       resp_idx_q, resp_idx_d;
    logic                  resp_err_q, resp_err_d;

    logic [NB_MASTERS-1:0] legal;
    logic [NB_MASTERS-1:0] resp_hit;
    logic [RR_W:0]         cand_sum;
    logic                  win_found;
    logic [RR_W-1:0]       win_idx;
    logic                  win_legal;
    logic                  grant;

    // Per-master classification: only reads inside the ROM window are legal.
    for (genvar g = 0; g < NB_MASTERS; g++) begin : g_cls
        assign legal[g] = m_wen_i[g]
                       && ({1'b0, m_add_i[g]} >= WIN_LO)
                       && ({1'b0, m_add_i[g]} <  WIN_HI);
    end

    // Round-robin search: first requester at or after rr_q, modulo NB_MASTERS.
    always_comb begin
        cand_sum  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            cand_sum = {1'b0, rr_q} + (RR_W+1)'(i);
            if (cand_sum >= NB_L) begin
                cand_sum = cand_sum - NB_L;
            end
            if (!win_found && m_req_i[cand_sum[RR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[RR_W-1:0];
            end
        end
    end

    // Grant decision and ROM request; everything is forced idle while in reset.
    always_comb begin
        win_legal = legal[win_idx];
        s_req_o   = rst_ni && win_found && win_legal;
        grant     = rst_ni && win_found && (!win_legal || s_gnt_i);
        s_add_o   = s_req_o ? m_add_i[win_idx] : '0;
    end

    // Next-state: pointer advances past the winner on a grant, response tracked one cycle.
    always_comb begin
        rr_d       = rr_q;
        resp_vld_d = 1'b0;
        resp_idx_d = resp_idx_q;
        resp_err_d = resp_err_q;
        if (grant) begin
            resp_vld_d = 1'b1;
            resp_idx_d = win_idx;
            resp_err_d = !win_legal;
            if (win_idx == LAST) begin
                rr_d = '0;
            end else begin
                rr_d = win_idx + 1'b1;
            end
        end
    end

    // State registers; reset discards any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            resp_vld_q <= 1'b0;
            resp_idx_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            resp_vld_q <= resp_vld_d;
            resp_idx_q <= resp_idx_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Grant fan-out and response routing to the master granted last cycle.
    for (genvar g = 0; g < NB_MASTERS; g++) begin : g_route
        assign m_gnt_o[g]     = grant && (win_idx == RR_W'(g));
        assign resp_hit[g]    = resp_vld_q && (resp_idx_q == RR_W'(g))
                             && (resp_err_q || s_r_valid_i);
        assign m_r_valid_o[g] = resp_hit[g];
        assign m_r_rdata_o[g] = resp_hit[g] ? (resp_err_q ? ERR_RDATA : s_r_rdata_i) : '0;
        assign m_r_opc_o[g]   = resp_hit[g] && resp_err_q;
    end

    // The ROM may only answer a ROM access granted in the previous cycle.
    a_rom_resp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        s_r_valid_i |-> (resp_vld_q && !resp_err_q));

endmodule

// File: doc/boot_rom_arbiter.md
# boot_rom_arbiter

Shares the SoC boot ROM slave port among NB_MASTERS TCDM-style requesters, such as the FC instruction fetch, the debug module and the JTAG/uDMA loaders. It arbitrates round-robin, forwards at most one request per cycle to the ROM, and routes each one-cycle-latency response back to the master that issued it. Write requests and addresses outside the ROM window never reach the ROM. They are answered locally with an error response that keeps the same one-cycle timing.

## Interface
Parameters:
- NB_MASTERS, 2: number of requester ports; valid range 1..8.
- ROM_ADDR_WIDTH, 13: byte-address width of the ROM window (window size 2^ROM_ADDR_WIDTH bytes).
- BASE_ADDR, 32'h1A00_0000: first byte address of the ROM window.
- ERR_RDATA, 32'hBADA_CCE5: rdata returned with an error response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- m_req_i  in  NB_MASTERS  per-master request.
- m_add_i  in  NB_MASTERS x 32  per-master byte address.
- m_wen_i  in  NB_MASTERS  per-master write-enable, active-low (1 = read, 0 = write).
- m_gnt_o  out  NB_MASTERS  per-master grant.
- m_r_valid_o  out  NB_MASTERS  per-master response valid.
- m_r_rdata_o  out  NB_MASTERS x 32  per-master response data.
- m_r_opc_o  out  NB_MASTERS  per-master response error (1 = error).
- s_req_o  out  1  request to ROM.
- s_add_o  out  32  address to ROM; the winner's address, unmodified.
- s_gnt_i  in  1  ROM grant.
- s_r_valid_i  in  1  ROM response valid.
- s_r_rdata_i  in  32  ROM response data.

## Operation
Request classification (combinational, per master):
- A request is legal when m_wen_i=1 and BASE_ADDR <= m_add_i < BASE_ADDR + 2^ROM_ADDR_WIDTH.
- Compute the range check as a 33-bit unsigned comparison so that a window ending at 2^32 does not wrap.

Arbitration:
- Round-robin pointer rr_q, log2(NB_MASTERS) bits wide (minimum 1). Reset value 0.
- The winner is the first requesting master at or after rr_q, searching modulo NB_MASTERS.
- A legal winner drives s_req_o=1 and s_add_o=m_add_i[winner]. It is granted only if s_gnt_i=1.
- An illegal winner is granted unconditionally. s_req_o stays 0 that cycle, so the ROM is not accessed.
- On any grant, rr_q <= winner+1, wrapping from NB_MASTERS-1 to 0. With no grant, rr_q holds.
- Only the winner can see m_gnt_o=1. At most one grant is issued per cycle.
- When nothing is requested: s_req_o=0 and s_add_o=0.

Response tracking registers (all reset to 0):
- On a grant: resp_vld_q <= 1, resp_idx_q <= winner, resp_err_q <= ~legal.
- Otherwise: resp_vld_q <= 0.

Response routing (combinational):
- m_r_valid_o[resp_idx_q] = resp_vld_q & (resp_err_q | s_r_valid_i). All other masters get 0.
- Responding master's rdata: ERR_RDATA if resp_err_q, else s_r_rdata_i. Its m_r_opc_o = resp_err_q.
- Non-responding masters get rdata 0 and r_opc 0.
- s_r_valid_i=1 while resp_vld_q=0 or resp_err_q=1 is a protocol violation. Assert on it in simulation; the response is dropped.

## Timing
- Grant is combinational, in the same cycle as the request.
- Response arrives exactly 1 cycle after the grant, for both ROM and error responses.
- Back-to-back grants are allowed every cycle. The response for cycle N grant and the grant for cycle N+1 overlap without stall.
- A master must hold m_req_i, m_add_i and m_wen_i stable until it is granted. A request may be withdrawn before its grant.
- If s_gnt_i=0 with a legal winner: no grant, rr_q holds, and the same master wins again next cycle unless its request was withdrawn.
- Reset mid-operation: the pending response is discarded, and all outputs take their reset values immediately (asynchronously).
- Reset values of outputs: m_gnt_o=0, m_r_valid_o=0, m_r_rdata_o=0, m_r_opc_o=0, s_req_o=0, s_add_o=0.
- NB_MASTERS=1: rr_q is held at 0 and behaviour is otherwise identical.

## Test plan
- Single read: M0 reads 0x1A00_0010 and the ROM model returns 0x1234_5678. Required: gnt in cycle 0, s_add_o=0x1A00_0010, then M0 r_valid=1, rdata=0x1234_5678, r_opc=0 in cycle 1.
- Round-robin fairness: M0 and M1 request continuously for 6 cycles from reset. Required: grants alternate M0, M1, M0, M1, M0, M1, with each response reaching the master granted the previous cycle.
- Out-of-range read: M1 reads 0x1A00_2000 (one past the window). Required: gnt=1, s_req_o=0, then next cycle M1 r_valid=1, r_opc=1, rdata=0xBADA_CCE5. A write to 0x1A00_0000 produces the same response.
- Mixed traffic: M0 makes an illegal access while M1 makes a legal access in the same cycle, rr_q=0. Required: M0 is granted with an error response; M1 is granted the next cycle with ROM data and no lost cycle.
- Slave backpressure: s_gnt_i=0 for 3 cycles while M1 requests. Required: no grant and rr_q unchanged during those cycles; grant when s_gnt_i rises, response one cycle later.
- Reset mid-transaction: assert rst_ni low in the cycle after a grant. Required: r_valid stays 0 and no response is delivered; after release the first request is arbitrated from rr_q=0.
